// File: rtl/fre_sweep_ctrl_if.sv
// Control/select and output signals of the DDS frequency controller.
// The master side drives table writes and go requests; the slave side is the controller itself.
interface fre_sweep_ctrl_if #(
  parameter int unsigned INC_W   = 32,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 16
);
  logic               wr_en;
  logic [SEL_W-1:0]   wr_addr;
  logic [INC_W-1:0]   wr_data;
  logic [SEL_W-1:0]   sel;
  logic               go;
  logic               mode;
  logic [INC_W-1:0]   step;
  logic [DWELL_W-1:0] dwell;
  logic [INC_W-1:0]   inc;
  logic               busy;
  logic               done;

  modport master (
    output wr_en, wr_addr, wr_data, sel, go, mode, step, dwell,
    input  inc, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, sel, go, mode, step, dwell,
    output inc, busy, done
  );
endinterface

// File: rtl/fre_sweep_ctrl.sv
// DDS tuning-word controller: writable word table, jump or linear sweep toward the selected word,
// one sweep step every dwell+1 cycles.
module fre_sweep_ctrl #(
  parameter int unsigned INC_W   = 32,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  fre_sweep_ctrl_if.slave  ctl
);

  localparam int unsigned Depth = 2 ** SEL_W;

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e             state_q, state_d;
  logic [INC_W-1:0]   tbl_q [Depth];
  logic [INC_W-1:0]   inc_q, inc_d;
  logic [INC_W-1:0]   target_q, target_d;
  logic [INC_W-1:0]   step_q, step_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               up_q, up_d;
  logic               done_q, done_d;
  logic [INC_W-1:0]   rd_word;
  logic [INC_W-1:0]   diff;

  // Write-first bypass so a go can pick up a word written in the same cycle.
  always_comb begin
    rd_word = tbl_q[ctl.sel];
    if (ctl.wr_en && (ctl.wr_addr == ctl.sel)) begin
      rd_word = ctl.wr_data;
    end
  end

  always_comb begin
    diff = up_q ? (target_q - inc_q) : (inc_q - target_q);
  end

  always_comb begin
    state_d  = state_q;
    inc_d    = inc_q;
    target_d = target_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    cnt_d    = cnt_q;
    up_d     = up_q;
    done_d   = 1'b0;

    if (ctl.go) begin
      // A go request overrides any pending step, whatever the state.
      if (!ctl.mode || (ctl.step == '0) || (rd_word == inc_q)) begin
        inc_d   = rd_word;
        done_d  = 1'b1;
        state_d = StIdle;
      end else begin
        target_d = rd_word;
        step_d   = ctl.step;
        dwell_d  = ctl.dwell;
        cnt_d    = ctl.dwell;
        up_d     = (rd_word > inc_q);
        state_d  = StSweep;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StSweep: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
          end else if (diff <= step_q) begin
            // Full-width distance check clamps the last step onto the target.
            inc_d   = target_q;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            inc_d = up_q ? (inc_q + step_q) : (inc_q - step_q);
            cnt_d = dwell_q;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      inc_q    <= '0;
      target_q <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      cnt_q    <= '0;
      up_q     <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      inc_q    <= inc_d;
      target_q <= target_d;
      step_q   <= step_d;
      dwell_q  <= dwell_d;
      cnt_q    <= cnt_d;
      up_q     <= up_d;
      done_q   <= done_d;
      if (ctl.wr_en) begin
        tbl_q[ctl.wr_addr] <= ctl.wr_data;
      end
    end
  end

  assign ctl.inc  = inc_q;
  assign ctl.busy = (state_q == StSweep);
  assign ctl.done = done_q;

endmodule

// File: tb/tb_fre_sweep_ctrl.sv
// Bench for fre_sweep_ctrl: a vector table for reset/jump/bypass, then hand-built sweep sequences,
// with expected outputs queued as stimulus is applied and checked after each edge.
module tb_fre_sweep_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fre_sweep_ctrl_if #(.INC_W(32), .SEL_W(3), .DWELL_W(16)) ctl ();

  fre_sweep_ctrl #(.INC_W(32), .SEL_W(3), .DWELL_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (ctl)
  );

  typedef struct {
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  sel;
    logic        go;
    logic        mode;
    logic [31:0] step;
    logic [15:0] dwell;
    logic [31:0] e_inc;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  typedef struct {
    string       tag;
    logic [31:0] inc;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t idle(input logic [31:0] e_inc, input logic e_busy, input logic e_done);
    vec_t v;
    v.rst = 1'b0; v.wr_en = 1'b0; v.wr_addr = '0; v.wr_data = '0;
    v.sel = '0; v.go = 1'b0; v.mode = 1'b0; v.step = '0; v.dwell = '0;
    v.e_inc = e_inc; v.e_busy = e_busy; v.e_done = e_done;
    return v;
  endfunction

  function automatic vec_t wr(input logic [2:0] a, input logic [31:0] d,
                              input logic [31:0] e_inc);
    vec_t v;
    v = idle(e_inc, 1'b0, 1'b0);
    v.wr_en = 1'b1; v.wr_addr = a; v.wr_data = d;
    return v;
  endfunction

  function automatic vec_t gov(input logic [2:0] s, input logic m, input logic [31:0] st,
                               input logic [15:0] dw, input logic [31:0] e_inc,
                               input logic e_busy, input logic e_done);
    vec_t v;
    v = idle(e_inc, e_busy, e_done);
    v.go = 1'b1; v.sel = s; v.mode = m; v.step = st; v.dwell = dw;
    return v;
  endfunction

  task automatic check1(input string tag, input string what, input logic [31:0] act,
                        input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s got %h expected %h", tag, what, act, req);
    end
  endtask

  // Drive at the falling edge, queue the expectation, compare just after the rising edge.
  task automatic apply(input string tag, input vec_t v);
    exp_t e;
    @(negedge clk);
    rst         = v.rst;
    ctl.wr_en   = v.wr_en;
    ctl.wr_addr = v.wr_addr;
    ctl.wr_data = v.wr_data;
    ctl.sel     = v.sel;
    ctl.go      = v.go;
    ctl.mode    = v.mode;
    ctl.step    = v.step;
    ctl.dwell   = v.dwell;
    exp_q.push_back('{tag: tag, inc: v.e_inc, busy: v.e_busy, done: v.e_done});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check1(e.tag, "inc", ctl.inc, e.inc);
    check1(e.tag, "busy", 32'(ctl.busy), 32'(e.busy));
    check1(e.tag, "done", 32'(ctl.done), 32'(e.done));
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    rst = 1'b1;
    ctl.wr_en = 1'b0; ctl.wr_addr = '0; ctl.wr_data = '0; ctl.sel = '0;
    ctl.go = 1'b0; ctl.mode = 1'b0; ctl.step = '0; ctl.dwell = '0;

    // Reset held two cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      v = idle(32'h0, 1'b0, 1'b0);
      v.rst = 1'b1; v.wr_en = 1'($urandom); v.wr_addr = 3'($urandom);
      v.wr_data = $urandom; v.sel = 3'($urandom); v.go = 1'($urandom);
      v.mode = 1'($urandom); v.step = $urandom; v.dwell = 16'($urandom);
      apply("reset", v);
    end

    tbl.push_back(gov(3'd5, 1'b0, 0, 0, 32'h0, 1'b0, 1'b1));
    tbl.push_back(idle(32'h0, 1'b0, 1'b0));
    tbl.push_back(wr(3'd1, 32'h00029F17, 32'h0));
    tbl.push_back(wr(3'd2, 32'h00053E2D, 32'h0));
    tbl.push_back(gov(3'd1, 1'b0, 0, 0, 32'h00029F17, 1'b0, 1'b1));
    tbl.push_back(idle(32'h00029F17, 1'b0, 1'b0));
    tbl.push_back(gov(3'd2, 1'b0, 0, 0, 32'h00053E2D, 1'b0, 1'b1));
    tbl.push_back(idle(32'h00053E2D, 1'b0, 1'b0));
    v = gov(3'd4, 1'b0, 0, 0, 32'h777, 1'b0, 1'b1);
    v.wr_en = 1'b1; v.wr_addr = 3'd4; v.wr_data = 32'h777;
    tbl.push_back(v);
    tbl.push_back(gov(3'd2, 1'b1, 0, 5, 32'h00053E2D, 1'b0, 1'b1));
    tbl.push_back(wr(3'd0, 32'h100, 32'h00053E2D));
    tbl.push_back(wr(3'd3, 32'h180, 32'h00053E2D));
    tbl.push_back(gov(3'd0, 1'b0, 0, 0, 32'h100, 1'b0, 1'b1));
    tbl.push_back(gov(3'd0, 1'b1, 32'h20, 3, 32'h100, 1'b0, 1'b1));
    for (int i = 0; i < tbl.size(); i++) apply($sformatf("vec%0d", i), tbl[i]);

    // Sweep up 0x100 -> 0x180, step 0x20, dwell 2: a step every third edge.
    apply("up_go", gov(3'd3, 1'b1, 32'h20, 16'd2, 32'h100, 1'b1, 1'b0));
    for (int k = 1; k <= 12; k++) begin
      apply($sformatf("up%0d", k),
            idle(32'h100 + 32'h20 * 32'(k / 3), (k < 12), (k == 12)));
    end
    apply("up_after", idle(32'h180, 1'b0, 1'b0));

    // Sweep down with clamp onto 0x105.
    apply("dn_wr", wr(3'd5, 32'h105, 32'h180));
    apply("dn_go", gov(3'd5, 1'b1, 32'h40, 16'd0, 32'h180, 1'b1, 1'b0));
    apply("dn1", idle(32'h140, 1'b1, 1'b0));
    apply("dn2", idle(32'h105, 1'b0, 1'b1));
    apply("dn3", idle(32'h105, 1'b0, 1'b0));

    // Retarget mid-sweep; the go also beats a counter expiry on the same edge.
    apply("rt_wr", wr(3'd6, 32'h305, 32'h105));
    apply("rt_go", gov(3'd6, 1'b1, 32'h100, 16'd1, 32'h105, 1'b1, 1'b0));
    apply("rt1", idle(32'h105, 1'b1, 1'b0));
    apply("rt2", idle(32'h205, 1'b1, 1'b0));
    apply("rt3", idle(32'h205, 1'b1, 1'b0));
    apply("rt_go2", gov(3'd0, 1'b1, 32'h80, 16'd0, 32'h205, 1'b1, 1'b0));
    apply("rt4", idle(32'h185, 1'b1, 1'b0));
    apply("rt5", idle(32'h105, 1'b1, 1'b0));
    apply("rt6", idle(32'h100, 1'b0, 1'b1));
    apply("rt7", idle(32'h100, 1'b0, 1'b0));

    // Jump out of a sweep with mode 0.
    apply("jx_go", gov(3'd3, 1'b1, 32'h10, 16'd3, 32'h100, 1'b1, 1'b0));
    apply("jx_jump", gov(3'd4, 1'b0, 0, 0, 32'h777, 1'b0, 1'b1));
    apply("jx_after", idle(32'h777, 1'b0, 1'b0));

    // Reset mid-sweep clears outputs and table.
    apply("rs_go", gov(3'd3, 1'b1, 32'h10, 16'd0, 32'h777, 1'b1, 1'b0));
    apply("rs1", idle(32'h767, 1'b1, 1'b0));
    v = idle(32'h0, 1'b0, 1'b0);
    v.rst = 1'b1;
    apply("rs_rst", v);
    apply("rs2", idle(32'h0, 1'b0, 1'b0));
    apply("rs_go2", gov(3'd3, 1'b0, 0, 0, 32'h0, 1'b0, 1'b1));
    apply("rs_go3", gov(3'd4, 1'b1, 32'h1, 16'd0, 32'h0, 1'b0, 1'b1));
    apply("rs3", idle(32'h0, 1'b0, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
